// File: rtl/xilinx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// xilinx_fifo_pkg
// Shared helpers for the block-RAM FIFO read-side adapter.
//   rd_latency(do_reg) : read latency of a non-FWFT FIFO18E1/FIFO36E1 (1 + DO_REG)
//   skid_depth(lat)    : skid entries needed to cover the in-flight words plus one
//   level_t            : 2-bit skid-buffer occupancy (0..3)
// -----------------------------------------------------------------------------
package xilinx_fifo_pkg;

  typedef logic [1:0] level_t;

  function automatic int rd_latency(input int do_reg);
    return 1 + do_reg;
  endfunction

  // One entry per in-flight read plus one, so that a full-rate stream never
  // has to drop RDEN while words are still in the pipe.
  function automatic int skid_depth(input int lat);
    return lat + 1;
  endfunction

endpackage

// File: rtl/xilinx_fifo_skid.sv
// -----------------------------------------------------------------------------
// xilinx_fifo_skid
// Small first-word-fall-through register FIFO. Entry 0 is always the head, so
// a pop shifts the remaining entries down by one.
//   clk, rst   : clock and synchronous active-high reset
//   push       : write push_data (ignored when full and not popping)
//   push_data  : word to write
//   pop        : remove head (ignored when empty)
//   level      : number of stored words, 0..DEPTH
//   head       : oldest stored word (zero after reset)
// -----------------------------------------------------------------------------
module xilinx_fifo_skid #(
  parameter int DATA_WIDTH = 36,
  parameter int DEPTH      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [DATA_WIDTH-1:0]        head
);

  localparam int LW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_n [DEPTH];
  logic [LW-1:0]         level_n;
  logic [LW-1:0]         wr_idx;
  logic                  pop_ok;
  logic                  push_ok;

  // Next-state of the entry array. When a pop and a push coincide the new
  // word lands one slot lower, because everything has just shifted down.
  always_comb begin
    mem_n   = mem;
    pop_ok  = pop && (level != '0);
    push_ok = push && ((level < LW'(DEPTH)) || pop_ok);
    wr_idx  = pop_ok ? (level - LW'(1)) : level;
    if (pop_ok) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_n[i] = mem[i+1];
      end
    end
    if (push_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (LW'(i) == wr_idx) begin
          mem_n[i] = push_data;
        end
      end
    end
    level_n = level + LW'(push_ok) - LW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      level <= level_n;
      mem   <= mem_n;
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/xilinx_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// xilinx_fifo_rd_stream
// Read-side adapter for a non-FWFT block-RAM sync FIFO (FIFO18E1/FIFO36E1).
// It issues RDEN against a credit count, tracks the fixed read latency with a
// valid shift pipe, catches returned words in a skid buffer and presents them
// as a valid/ready stream at one word per cycle.
//
// Ports:
//   CLK, RST    : clock shared with the FIFO, synchronous active-high reset
//   FIFO_EMPTY  : FIFO EMPTY flag
//   FIFO_RDEN   : FIFO read enable (held low during the post-reset hold-off)
//   FIFO_DO     : FIFO data output, valid RD_LATENCY cycles after RDEN
//   FIFO_RDERR  : FIFO RDERR flag
//   M_VALID     : stream valid (skid buffer not empty)
//   M_READY     : stream ready
//   M_DATA      : stream data, the skid-buffer head
//   M_LEVEL     : skid-buffer occupancy, 0..RD_LATENCY+1
//   ERR         : sticky error, cleared only by RST
//
// Build option:
//   XILINX_FIFO_RD_STREAM_RDERR_CHECK_EN - fold FIFO_RDERR into ERR and add
//   simulation assertions for RDERR and skid-buffer overflow.
// -----------------------------------------------------------------------------
module xilinx_fifo_rd_stream
  import xilinx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 36,
  parameter int RD_LATENCY  = 2,
  parameter int RST_HOLDOFF = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FIFO_EMPTY,
  output logic                  FIFO_RDEN,
  input  logic [DATA_WIDTH-1:0] FIFO_DO,
  input  logic                  FIFO_RDERR,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic [1:0]            M_LEVEL,
  output logic                  ERR
);

  localparam int SKID_DEPTH = skid_depth(RD_LATENCY);
  localparam int CW         = $clog2(RD_LATENCY + SKID_DEPTH + 1);
  localparam int HW         = (RST_HOLDOFF < 1) ? 1 : $clog2(RST_HOLDOFF + 1);

  logic [RD_LATENCY-1:0] pipe;
  logic [RD_LATENCY-1:0] pipe_n;
  logic [HW-1:0]         holdoff;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         cnt;
  level_t                skid_level;
  logic                  push;
  logic                  pop;
  logic                  err;

  assign push    = pipe[RD_LATENCY-1];
  assign M_VALID = (skid_level != '0);
  assign pop     = M_VALID && M_READY;
  assign M_LEVEL = skid_level;
  assign ERR     = err;

  // Credit check: every word already requested (in the pipe) or buffered owns
  // a skid slot, so RDEN is only raised when a slot is guaranteed to be free
  // by the time the word returns. RST gates RDEN so nothing is read while the
  // adapter is being cleared.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(pipe[i]);
    end
    cnt       = inflight + CW'(skid_level);
    FIFO_RDEN = !RST && (holdoff == '0) && !FIFO_EMPTY &&
                ((cnt - CW'(pop)) < CW'(SKID_DEPTH));
    pipe_n    = pipe << 1;
    pipe_n[0] = FIFO_RDEN;
  end

  // Latency pipe, post-reset hold-off counter and the sticky error flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pipe    <= '0;
      holdoff <= HW'(RST_HOLDOFF);
      err     <= 1'b0;
    end else begin
      pipe <= pipe_n;
      if (holdoff != '0) begin
        holdoff <= holdoff - HW'(1);
      end
`ifdef XILINX_FIFO_RD_STREAM_RDERR_CHECK_EN
      err <= err || (FIFO_RDEN && FIFO_EMPTY) || FIFO_RDERR;
`else
      err <= err || (FIFO_RDEN && FIFO_EMPTY);
`endif
    end
  end

`ifdef XILINX_FIFO_RD_STREAM_RDERR_CHECK_EN
  a_no_rderr : assert property (@(posedge CLK) disable iff (RST) !FIFO_RDERR)
    else $error("xilinx_fifo_rd_stream: FIFO_RDERR asserted");

  a_no_overflow : assert property (@(posedge CLK) disable iff (RST)
    !(push && (skid_level == level_t'(SKID_DEPTH)) && !pop))
    else $error("xilinx_fifo_rd_stream: push into full skid buffer");
`else
  logic rderr_unused;
  assign rderr_unused = FIFO_RDERR;
`endif

  xilinx_fifo_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_skid (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (FIFO_DO),
    .pop       (pop),
    .level     (skid_level),
    .head      (M_DATA)
  );

endmodule
